// File: rtl/thread_fetch_sched.sv
// thread_fetch_sched: barrel-style round-robin fetch PC scheduler with per-thread redirect and halt
module thread_fetch_sched #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_THREADS = 4,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_STRIDE = 32'h0000_0100,
  localparam int TID_W = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [ADDRESS_WIDTH-1:0] fetch_pc,
  output logic [TID_W-1:0]         fetch_tid,
  input  logic                     redirect_valid,
  input  logic [TID_W-1:0]         redirect_tid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     halt_valid,
  input  logic [TID_W-1:0]         halt_tid,
  output logic [NUM_THREADS-1:0]   thread_active,
  output logic                     all_halted
);
  logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
  logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0]   active_q, active_d;
  logic [TID_W-1:0]         ptr_q, ptr_d, sel, idx;
  logic                     issue;
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NUM_THREADS - 1; k >= 0; k--) begin
      idx = ptr_q + TID_W'(k);
      if (active_q[idx]) sel = idx;
    end
    fetch_valid = |active_q;
    fetch_tid = sel;
    fetch_pc = fetch_valid ? pc_q[sel] : '0;
    thread_active = active_q;
    all_halted = ~|active_q;
    issue = fetch_valid & fetch_ready;
    pc_d = pc_q;
    active_d = active_q;
    ptr_d = issue ? sel + TID_W'(1) : ptr_q;
    if (issue) pc_d[sel] = pc_q[sel] + ADDRESS_WIDTH'(4);
    if (redirect_valid) pc_d[redirect_tid] = redirect_pc;
    if (halt_valid) active_d[halt_tid] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_q <= '1;
      ptr_q <= '0;
      for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= RESET_PC + ADDRESS_WIDTH'(i) * THREAD_STRIDE;
    end else begin
      active_q <= active_d;
      ptr_q <= ptr_d;
      pc_q <= pc_d;
    end
  end
endmodule

// File: tb/tb_thread_fetch_sched.sv
// tb_thread_fetch_sched: directed self-checking bench for the fetch scheduler
module tb_thread_fetch_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_valid, fetch_ready = 1'b0;
  logic [31:0] fetch_pc;
  logic [1:0]  fetch_tid;
  logic        redirect_valid = 1'b0;
  logic [1:0]  redirect_tid = '0;
  logic [31:0] redirect_pc = '0;
  logic        halt_valid = 1'b0;
  logic [1:0]  halt_tid = '0;
  logic [3:0]  thread_active;
  logic        all_halted;
  int          checks = 0;
  int          errors = 0;
  thread_fetch_sched dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_tid(fetch_tid), .redirect_valid(redirect_valid),
    .redirect_tid(redirect_tid), .redirect_pc(redirect_pc), .halt_valid(halt_valid),
    .halt_tid(halt_tid), .thread_active(thread_active), .all_halted(all_halted)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic apply_reset();
    rst = 1'b0;
    fetch_ready = 1'b0;
    redirect_valid = 1'b0;
    halt_valid = 1'b0;
    step();
    rst = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    fetch_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_tid = 2'd0;
    redirect_pc = 32'h55;
    halt_valid = 1'b1;
    halt_tid = 2'd0;
    step();
    rst = 1'b1;
    redirect_valid = 1'b0;
    halt_valid = 1'b0;
    fetch_ready = 1'b0;
    checks++; if (fetch_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %0b exp 1", fetch_valid); end
    checks++; if (fetch_tid !== 2'd0) begin errors++; $display("FAIL reset_tid got %0d exp 0", fetch_tid); end
    checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", fetch_pc); end
    checks++; if (thread_active !== 4'hf) begin errors++; $display("FAIL reset_active got %b exp 1111", thread_active); end
    checks++; if (all_halted !== 1'b0) begin errors++; $display("FAIL reset_all_halted got %0b exp 0", all_halted); end
  endtask
  task automatic test_barrel();
    logic [31:0] exp_pc;
    apply_reset();
    fetch_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_pc = 32'(i / 4) * 32'd4 + 32'(i % 4) * 32'h100;
      checks++; if (fetch_tid !== 2'(i % 4)) begin errors++; $display("FAIL barrel_tid[%0d] got %0d exp %0d", i, fetch_tid, i % 4); end
      checks++; if (fetch_pc !== exp_pc) begin errors++; $display("FAIL barrel_pc[%0d] got %h exp %h", i, fetch_pc, exp_pc); end
      step();
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (fetch_pc !== 32'h0 || fetch_tid !== 2'd0) begin errors++; $display("FAIL midop_reset got tid %0d pc %h exp tid 0 pc 0", fetch_tid, fetch_pc); end
  endtask
  task automatic test_stall();
    apply_reset();
    fetch_ready = 1'b1;
    step();
    step();
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_tid !== 2'd2 || fetch_pc !== 32'h200) begin errors++; $display("FAIL stall_hold[%0d] got tid %0d pc %h exp tid 2 pc 200", i, fetch_tid, fetch_pc); end
      step();
    end
    fetch_ready = 1'b1;
    checks++; if (fetch_tid !== 2'd2 || fetch_pc !== 32'h200) begin errors++; $display("FAIL stall_release got tid %0d pc %h exp tid 2 pc 200", fetch_tid, fetch_pc); end
    step();
    checks++; if (fetch_tid !== 2'd3 || fetch_pc !== 32'h300) begin errors++; $display("FAIL stall_next got tid %0d pc %h exp tid 3 pc 300", fetch_tid, fetch_pc); end
  endtask
  task automatic test_redirect();
    logic [1:0]  et [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] ep [4] = '{32'h200, 32'h300, 32'h004, 32'h800};
    apply_reset();
    fetch_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_tid = 2'd1;
    redirect_pc = 32'h800;
    checks++; if (fetch_tid !== 2'd1) begin errors++; $display("FAIL redirect_offer got tid %0d exp 1", fetch_tid); end
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (fetch_tid !== et[i] || fetch_pc !== ep[i]) begin errors++; $display("FAIL redirect_seq[%0d] got tid %0d pc %h exp tid %0d pc %h", i, fetch_tid, fetch_pc, et[i], ep[i]); end
      step();
    end
  endtask
  task automatic test_halt();
    logic [1:0]  et [7] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    logic [31:0] ep [7] = '{32'h000, 32'h200, 32'h004, 32'h204, 32'h008, 32'h208, 32'h00c};
    apply_reset();
    halt_valid = 1'b1;
    halt_tid = 2'd1;
    step();
    halt_tid = 2'd3;
    step();
    halt_valid = 1'b0;
    checks++; if (thread_active !== 4'b0101) begin errors++; $display("FAIL halt_active got %b exp 0101", thread_active); end
    fetch_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) begin
        fetch_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_tid = 2'd3;
        redirect_pc = 32'h900;
        step();
        redirect_valid = 1'b0;
        fetch_ready = 1'b1;
      end
      checks++; if (fetch_tid !== et[i] || fetch_pc !== ep[i]) begin errors++; $display("FAIL halt_seq[%0d] got tid %0d pc %h exp tid %0d pc %h", i, fetch_tid, fetch_pc, et[i], ep[i]); end
      step();
    end
    checks++; if (thread_active !== 4'b0101) begin errors++; $display("FAIL halt_redirect_active got %b exp 0101", thread_active); end
  endtask
  task automatic test_all_halted();
    apply_reset();
    halt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      halt_tid = 2'(i);
      step();
    end
    halt_valid = 1'b0;
    checks++; if (all_halted !== 1'b1) begin errors++; $display("FAIL all_halted got %0b exp 1", all_halted); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL halted_valid got %0b exp 0", fetch_valid); end
    checks++; if (fetch_pc !== 32'h0 || fetch_tid !== 2'd0) begin errors++; $display("FAIL halted_outputs got tid %0d pc %h exp tid 0 pc 0", fetch_tid, fetch_pc); end
    checks++; if (thread_active !== 4'b0000) begin errors++; $display("FAIL halted_active got %b exp 0000", thread_active); end
    fetch_ready = 1'b1;
    step();
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL halted_stays got %0b exp 0", fetch_valid); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (fetch_valid !== 1'b1 || fetch_tid !== 2'd0 || fetch_pc !== 32'h0) begin errors++; $display("FAIL rereset_fetch got v %0b tid %0d pc %h exp v 1 tid 0 pc 0", fetch_valid, fetch_tid, fetch_pc); end
    checks++; if (thread_active !== 4'hf || all_halted !== 1'b0) begin errors++; $display("FAIL rereset_active got %b/%0b exp 1111/0", thread_active, all_halted); end
  endtask
  task automatic test_wrap();
    apply_reset();
    redirect_valid = 1'b1;
    redirect_tid = 2'd0;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (fetch_tid !== 2'd0 || fetch_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_preload got tid %0d pc %h exp tid 0 pc fffffffc", fetch_tid, fetch_pc); end
    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (fetch_tid !== 2'd0 || fetch_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got tid %0d pc %h exp tid 0 pc 0", fetch_tid, fetch_pc); end
  endtask
  initial begin
    test_reset();
    test_barrel();
    test_stall();
    test_redirect();
    test_halt();
    test_all_halted();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
